// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter: FSM states,
// requester IDs and the read-return tag carried through the latency pipe.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DEF   = 12;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned RD_LAT_DEF   = 1;
  localparam int unsigned MAX_WAIT_DEF = 8;

  typedef enum logic {
    PRI_CPU   = 1'b0,
    FORCE_AUX = 1'b1
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports plus the dmem pins. The arbiter takes the
// slave view; the requesters and memory together form the master view.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              cpu_req,   aux_req;
  logic              cpu_we,    aux_we;
  logic [ADDR_W-1:0] cpu_addr,  aux_addr;
  logic [DATA_W-1:0] cpu_wdata, aux_wdata;
  logic              cpu_gnt,   aux_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid, aux_rvalid;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic [DATA_W-1:0] q_dmem;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    input  q_dmem,
    output cpu_gnt, aux_gnt, cpu_stall, cpu_rvalid, aux_rvalid, rdata,
    output address_dmem, data, wren
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output aux_req, aux_we, aux_addr, aux_wdata,
    output q_dmem,
    input  cpu_gnt, aux_gnt, cpu_stall, cpu_rvalid, aux_rvalid, rdata,
    input  address_dmem, data, wren
  );

endinterface

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// Delay line of {valid, port} tags matching the dmem read latency, so each
// returning word is steered to the port that issued the read.
module rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = RD_LAT_DEF
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every stage is reset, not just the head; a stale valid bit deeper in the line would fire an rvalid after reset.
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port dmem arbiter: CPU has fixed priority, a starvation counter forces
// an AUX grant after MAX_WAIT consecutive denials, read data routed by tag.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned RD_LAT   = RD_LAT_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF,
  localparam int unsigned WAIT_W  = $clog2(MAX_WAIT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     bus,
  output logic [15:0]       conflict_cnt_o,
  output arb_state_e        state_o,
  output logic [WAIT_W-1:0] wait_cnt_o
);

  arb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q,  wait_d;
  logic [15:0]       conflict_q, conflict_d;

  logic              cpu_gnt, aux_gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  rd_tag_t           issue_tag, ret_tag;

  // Grants are gated by reset so nothing reaches dmem while it is asserted.
  always_comb begin
    // NOTE: defaults first keep every path assigned, so no latch is inferred.
    cpu_gnt = 1'b0;
    aux_gnt = 1'b0;
    if (!rst) begin
      if (state_q == FORCE_AUX) begin
        aux_gnt = bus.aux_req;
      end else begin
        cpu_gnt = bus.cpu_req;
        aux_gnt = bus.aux_req & ~bus.cpu_req;
      end
    end
  end

  always_comb begin
    state_d    = PRI_CPU;
    wait_d     = '0;
    conflict_d = conflict_q;
    if (bus.aux_req && !aux_gnt) begin
      if (wait_q == WAIT_W'(MAX_WAIT - 1)) state_d = FORCE_AUX;
      else                                 wait_d  = wait_q + 1'b1;
    end
    if (bus.cpu_req && bus.aux_req && conflict_q != 16'hFFFF)
      conflict_d = conflict_q + 16'd1;
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (cpu_gnt) begin
      sel_we    = bus.cpu_we;
      sel_addr  = bus.cpu_addr;
      sel_wdata = bus.cpu_wdata;
    end else if (aux_gnt) begin
      sel_we    = bus.aux_we;
      sel_addr  = bus.aux_addr;
      sel_wdata = bus.aux_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PRI_CPU;
      wait_q     <= '0;
      conflict_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the same pre-edge values.
      state_q    <= state_d;
      wait_q     <= wait_d;
      conflict_q <= conflict_d;
    end
  end

  assign issue_tag.valid = (cpu_gnt | aux_gnt) & ~sel_we;
  assign issue_tag.port  = aux_gnt ? PORT_AUX : PORT_CPU;

  rd_tag_pipe #(.DEPTH(RD_LAT)) u_tags (
    .clk   (clk),
    .rst   (rst),
    .tag_i (issue_tag),
    .tag_o (ret_tag)
  );

  assign bus.cpu_gnt      = cpu_gnt;
  assign bus.aux_gnt      = aux_gnt;
  assign bus.cpu_stall    = bus.cpu_req & ~cpu_gnt & ~rst;
  assign bus.address_dmem = sel_addr;
  assign bus.data         = sel_wdata;
  assign bus.wren         = sel_we & (cpu_gnt | aux_gnt);
  assign bus.cpu_rvalid   = ret_tag.valid & (ret_tag.port == PORT_CPU);
  assign bus.aux_rvalid   = ret_tag.valid & (ret_tag.port == PORT_AUX);
  assign bus.rdata        = bus.q_dmem;

  assign conflict_cnt_o = conflict_q;
  assign state_o        = state_q;
  assign wait_cnt_o     = wait_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int RD_LAT   = 1;
  localparam int MAX_WAIT = 8;

  logic clk, rst;
  logic [15:0] conflict_cnt;
  arb_state_e  state;
  logic [3:0]  wait_cnt;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .conflict_cnt_o (conflict_cnt),
    .state_o        (state),
    .wait_cnt_o     (wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory contents before any write: a recognisable per-address pattern.
  function automatic logic [31:0] pat(input logic [11:0] a);
    return {8'hA5, a, ~a};
  endfunction

  // dmem stand-in driven only by the DUT's memory pins.
  bit   [31:0] dmem  [4096];
  bit          dm_wm [4096];
  logic [31:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= dm_wm[bus.address_dmem] ? dmem[bus.address_dmem] : pat(bus.address_dmem);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (bus.wren) begin
      dmem[bus.address_dmem]  <= bus.data;
      dm_wm[bus.address_dmem] <= 1'b1;
    end
  end
  assign bus.q_dmem = rd_pipe[RD_LAT-1];

  // Reference model: memory image, expected read returns, denial streak.
  typedef struct { int due; logic port; logic [31:0] data; } rd_exp_t;
  rd_exp_t     rq[$];
  bit   [31:0] ref_mem [4096];
  bit          ref_wm  [4096];
  bit          m_forced;
  int          m_denied, m_conf, m_cyc;

  typedef struct packed {
    logic cpu_gnt, aux_gnt, cpu_stall, cpu_rvalid, aux_rvalid, wren;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic [15:0] conflict;
    logic [7:0]  waitc;
    logic        forced;
  } snap_t;
  snap_t got_s, want_s;

  task automatic model_clear;
    m_forced = 1'b0;
    m_denied = 0;
    m_conf   = 0;
    rq.delete();
  endtask

  task automatic drive(input logic cr, cw, input logic [11:0] ca, input logic [31:0] cd,
                       input logic ar, aw, input logic [11:0] aa, input logic [31:0] ad);
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.aux_req = ar; bus.aux_we = aw; bus.aux_addr = aa; bus.aux_wdata = ad;
  endtask

  // One clock cycle: drive, sample observed outputs, form expectations, advance model.
  task automatic step(input logic cr, cw, input logic [11:0] ca, input logic [31:0] cd,
                      input logic ar, aw, input logic [11:0] aa, input logic [31:0] ad);
    logic        p, we;
    logic [11:0] a;
    logic [31:0] d;
    @(negedge clk);
    drive(cr, cw, ca, cd, ar, aw, aa, ad);
    #1;
    want_s = '0;
    if (m_forced) want_s.aux_gnt = ar;
    else begin
      want_s.cpu_gnt = cr;
      want_s.aux_gnt = ar && !cr;
    end
    want_s.cpu_stall = cr && !want_s.cpu_gnt;
    if (want_s.cpu_gnt) begin
      want_s.addr = ca; want_s.data = cd; want_s.wren = cw;
    end else if (want_s.aux_gnt) begin
      want_s.addr = aa; want_s.data = ad; want_s.wren = aw;
    end
    if (rq.size() != 0 && rq[0].due == m_cyc) begin
      if (rq[0].port) want_s.aux_rvalid = 1'b1;
      else            want_s.cpu_rvalid = 1'b1;
      want_s.rdata = rq[0].data;
      void'(rq.pop_front());
    end
    want_s.conflict = 16'(m_conf);
    want_s.waitc    = 8'(m_denied);
    want_s.forced   = m_forced;

    got_s.cpu_gnt    = bus.cpu_gnt;
    got_s.aux_gnt    = bus.aux_gnt;
    got_s.cpu_stall  = bus.cpu_stall;
    got_s.cpu_rvalid = bus.cpu_rvalid;
    got_s.aux_rvalid = bus.aux_rvalid;
    got_s.wren       = bus.wren;
    got_s.addr       = bus.address_dmem;
    got_s.data       = bus.data;
    got_s.rdata      = (bus.cpu_rvalid || bus.aux_rvalid) ? bus.rdata : 32'h0;
    got_s.conflict   = conflict_cnt;
    got_s.waitc      = 8'(wait_cnt);
    got_s.forced     = (state == FORCE_AUX);

    if (want_s.cpu_gnt || want_s.aux_gnt) begin
      p  = want_s.aux_gnt;
      we = p ? aw : cw;
      a  = p ? aa : ca;
      d  = p ? ad : cd;
      if (we) begin
        ref_mem[a] = d;
        ref_wm[a]  = 1'b1;
      end else begin
        rq.push_back('{due: m_cyc + RD_LAT, port: p, data: (ref_wm[a] ? ref_mem[a] : pat(a))});
      end
    end
    if (cr && ar && m_conf < 65535) m_conf++;
    if (ar && !want_s.aux_gnt) begin
      m_denied++;
      m_forced = (m_denied == MAX_WAIT);
      if (m_forced) m_denied = 0;
    end else begin
      m_denied = 0;
      m_forced = 1'b0;
    end
    m_cyc++;
  endtask

  task automatic idle;
    step(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    drive(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1, 1, 12'h3, 32'h1, 1, 1, 12'h4, 32'h2);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({bus.cpu_gnt, bus.aux_gnt, bus.cpu_stall, bus.cpu_rvalid, bus.aux_rvalid, bus.wren} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=000000",
               {bus.cpu_gnt, bus.aux_gnt, bus.cpu_stall, bus.cpu_rvalid, bus.aux_rvalid, bus.wren});
    end
    total++;
    if (conflict_cnt !== 16'h0 || wait_cnt !== 4'h0 || state !== PRI_CPU) begin
      bad++;
      $display("FAIL reset_state got conflict=%h wait=%h state=%0d want 0/0/PRI_CPU", conflict_cnt, wait_cnt, state);
    end
    @(negedge clk);
    drive(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_cpu_only;
    int seen = 0;
    do_reset();
    step(1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 12'h0, 32'h0);
    total++;
    if (got_s !== want_s) begin bad++; $display("FAIL cpu_write got=%h want=%h", got_s, want_s); end
    step(1, 0, 12'h010, 32'h0, 0, 0, 12'h0, 32'h0);
    total++;
    if (got_s !== want_s) begin bad++; $display("FAIL cpu_read got=%h want=%h", got_s, want_s); end
    for (int i = 0; i < RD_LAT + 1; i++) begin
      idle();
      total++;
      if (got_s !== want_s) begin bad++; $display("FAIL cpu_drain got=%h want=%h", got_s, want_s); end
      if (got_s.cpu_rvalid && got_s.rdata == 32'hDEADBEEF) seen++;
    end
    total++;
    if (seen !== 1) begin bad++; $display("FAIL cpu_readback got=%0d want=1", seen); end
  endtask

  task automatic test_aux_reads;
    int seen = 0;
    do_reset();
    for (int i = 0; i < 4 + RD_LAT; i++) begin
      if (i < 4) step(0, 0, 12'h0, 32'h0, 1, 0, 12'(i), 32'h0);
      else       idle();
      total++;
      if (got_s !== want_s) begin bad++; $display("FAIL aux_reads c%0d got=%h want=%h", i, got_s, want_s); end
      if (got_s.aux_rvalid) seen++;
    end
    total++;
    if (seen !== 4) begin bad++; $display("FAIL aux_rvalid_count got=%0d want=4", seen); end
  endtask

  task automatic test_starvation;
    do_reset();
    for (int i = 1; i <= 27; i++) begin
      step(1, 0, 12'h020, 32'h0, 1, 0, 12'h021, 32'h0);
      total++;
      if (got_s !== want_s) begin bad++; $display("FAIL starve c%0d got=%h want=%h", i, got_s, want_s); end
      total++;
      if (got_s.aux_gnt !== (i % 9 == 0) || got_s.cpu_stall !== (i % 9 == 0)) begin
        bad++;
        $display("FAIL starve_bound c%0d got aux_gnt=%b stall=%b want %b", i, got_s.aux_gnt, got_s.cpu_stall, (i % 9 == 0));
      end
    end
    idle();
    total++;
    if (got_s.conflict !== 16'd27) begin bad++; $display("FAIL starve_conflicts got=%0d want=27", got_s.conflict); end
  endtask

  task automatic test_abandoned;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 12'h030, 32'h0, 1, 0, 12'h031, 32'h0);
      total++;
      if (got_s !== want_s) begin bad++; $display("FAIL abandon_pre c%0d got=%h want=%h", i, got_s, want_s); end
    end
    step(1, 0, 12'h030, 32'h0, 0, 0, 12'h031, 32'h0);
    total++;
    if (got_s !== want_s) begin bad++; $display("FAIL abandon got=%h want=%h", got_s, want_s); end
    total++;
    if (got_s.cpu_gnt !== 1'b0 || got_s.aux_gnt !== 1'b0 || got_s.forced !== 1'b1) begin
      bad++;
      $display("FAIL abandon_nogrant got gnt=%b%b forced=%b want 00 forced=1", got_s.cpu_gnt, got_s.aux_gnt, got_s.forced);
    end
    idle();
    total++;
    if (got_s.forced !== 1'b0 || got_s.waitc !== 8'd0) begin
      bad++;
      $display("FAIL abandon_return got forced=%b wait=%0d want 0/0", got_s.forced, got_s.waitc);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int i = 0; i < 8 + RD_LAT; i++) begin
      if (i >= 8)         idle();
      else if (i % 2 == 0) step(1, 0, 12'(12'h100 + i), 32'h0, 0, 0, 12'h0, 32'h0);
      else                 step(0, 0, 12'h0, 32'h0, 1, 0, 12'(12'h200 + i), 32'h0);
      total++;
      if (got_s !== want_s) begin bad++; $display("FAIL b2b c%0d got=%h want=%h", i, got_s, want_s); end
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 12'h040, 32'h0, 0, 0, 12'h0, 32'h0);
      total++;
      if (got_s !== want_s) begin bad++; $display("FAIL rmid_pre c%0d got=%h want=%h", i, got_s, want_s); end
    end
    step(1, 1, 12'h041, 32'h12345678, 1, 0, 12'h005, 32'h0);
    total++;
    if (got_s !== want_s) begin bad++; $display("FAIL rmid_conflict got=%h want=%h", got_s, want_s); end
    step(0, 0, 12'h0, 32'h0, 1, 0, 12'h005, 32'h0);
    total++;
    if (got_s !== want_s) begin bad++; $display("FAIL rmid_grant got=%h want=%h", got_s, want_s); end
    #1 rst = 1'b1;
    #1;
    total++;
    if (bus.aux_gnt !== 1'b0 || bus.wren !== 1'b0 || bus.aux_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_drop got gnt=%b wren=%b rvalid=%b want 0", bus.aux_gnt, bus.wren, bus.aux_rvalid);
    end
    model_clear();
    @(negedge clk);
    drive(0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < RD_LAT + 2; i++) begin
      idle();
      total++;
      if (got_s !== want_s) begin bad++; $display("FAIL rmid_post c%0d got=%h want=%h", i, got_s, want_s); end
    end
  endtask

  task automatic test_random;
    logic        cp, cw, ap, aw;
    logic [11:0] ca, aa;
    logic [31:0] cd, ad;
    cp = 0; cw = 0; ca = '0; cd = '0;
    ap = 0; aw = 0; aa = '0; ad = '0;
    do_reset();
    for (int i = 0; i < 400 + RD_LAT; i++) begin
      if (i < 400) begin
        if (!cp && $urandom_range(0, 3) != 0) begin
          cp = 1'b1; cw = 1'($urandom_range(0, 1)); ca = 12'($urandom_range(0, 15)); cd = $urandom;
        end
        if (!ap && $urandom_range(0, 1) != 0) begin
          ap = 1'b1; aw = 1'($urandom_range(0, 1)); aa = 12'($urandom_range(0, 15)); ad = $urandom;
        end
        step(cp, cw, ca, cd, ap, aw, aa, ad);
      end else begin
        idle();
      end
      total++;
      if (got_s !== want_s) begin bad++; $display("FAIL random c%0d got=%h want=%h", i, got_s, want_s); end
      if (want_s.cpu_gnt) cp = 1'b0;
      if (want_s.aux_gnt) ap = 1'b0;
    end
  endtask

  task automatic test_saturation;
    do_reset();
    for (int i = 0; i < 70000; i++) begin
      step(1, 0, 12'h050, 32'h0, 1, 0, 12'h051, 32'h0);
      total++;
      if (got_s !== want_s) begin bad++; $display("FAIL saturate c%0d got=%h want=%h", i, got_s, want_s); end
    end
    idle();
    total++;
    if (got_s.conflict !== 16'hFFFF) begin bad++; $display("FAIL saturate_hold got=%h want=ffff", got_s.conflict); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    m_cyc = 0;
    model_clear();
    test_reset();
    test_cpu_only();
    test_aux_reads();
    test_starvation();
    test_abandoned();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the processor's load/store stage (CPU port) and an auxiliary requester such as a program loader or debug reader (AUX port). The CPU has fixed priority, and a starvation counter forces an occasional AUX grant. A tag pipeline routes read data back to the port that issued each read. The block sits between the processor and the dmem instance at the top level and drives the dmem address, data and write-enable pins.

## Interface
- ADDR_W, 12, dmem word-address width
- DATA_W, 32, data width
- RD_LAT, 1, cycles from grant edge to valid q_dmem; legal range 1..4
- MAX_WAIT, 8, consecutive cycles AUX may be denied before a forced grant; legal range 2..255
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- cpu_req / aux_req  in  1  access request, one per port
- cpu_we / aux_we  in  1  1 = write, 0 = read
- cpu_addr / aux_addr  in  ADDR_W  word address
- cpu_wdata / aux_wdata  in  DATA_W  write data
- cpu_gnt / aux_gnt  out  1  access issued to dmem this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt; processor holds its memory stage
- cpu_rvalid / aux_rvalid  out  1  read data for this port is on rdata
- rdata  out  DATA_W  equals q_dmem, shared by both ports
- address_dmem  out  ADDR_W  address to dmem
- data  out  DATA_W  write data to dmem
- wren  out  1  write enable to dmem
- q_dmem  in  DATA_W  dmem read data
- conflict_cnt  out  16  saturating count of cycles in which both ports requested

## Operation
- FSM has two states.
- **PRI_CPU** (reset state):
  - If cpu_req, grant CPU.
  - Otherwise, if aux_req, grant AUX.
- **FORCE_AUX**:
  - If aux_req, grant AUX, even when cpu_req is high; cpu_stall=1 in that case.
  - Go to PRI_CPU unconditionally next cycle. If aux_req is low, nothing is granted.
- wait_cnt (width ceil(log2(MAX_WAIT+1))):
  - Increments when aux_req & ~aux_gnt.
  - Clears when AUX is granted or aux_req is low.
  - When wait_cnt==MAX_WAIT-1 and it would increment, next state is FORCE_AUX and wait_cnt clears.
- Grants are combinational from the current-cycle requests and state. At most one grant per cycle.
- Memory mux: address_dmem, data and wren come from the granted port.
  - wren = gnt & we.
  - With no grant: address_dmem=0, data=0, wren=0.
- Read tag pipeline:
  - RD_LAT stages, each holding {valid, port}.
  - Stage 0 is loaded with valid = gnt & ~we and port = the granted port.
  - The last stage drives cpu_rvalid or aux_rvalid; both are never high together.
  - Writes create no rvalid.
- conflict_cnt increments when cpu_req & aux_req and saturates at 16'hFFFF.

## Timing
- Reset values:
  - State PRI_CPU, wait_cnt 0, all tag stages invalid, conflict_cnt 0.
  - While reset is high: gnt, rvalid and wren are 0 and cpu_stall is 0, regardless of requests.
- Grant and issue happen in the same cycle N as the request.
- Read data: the rvalid for a grant in cycle N is high in cycle N+RD_LAT, together with rdata.
- Back-to-back reads from alternating ports keep issue order; one rvalid per cycle.
- Simultaneous requests in PRI_CPU: CPU is granted, AUX waits and wait_cnt increments.
- Forced-grant bound: with CPU requesting every cycle, AUX is granted exactly every MAX_WAIT+1 cycles.
- If aux_req drops while in FORCE_AUX, there is no grant; return to PRI_CPU with wait_cnt 0.
- Reset mid-read: in-flight tags are discarded and no rvalid is produced after reset deasserts.
- A requester must hold req, we, addr and wdata stable until its gnt; the arbiter does not latch them.

## Structure
- Package dmem_arb_pkg holds:
  - State enum PRI_CPU/FORCE_AUX.
  - Port ID constants PORT_CPU=0, PORT_AUX=1.
  - Default parameter values.
- Sub-module rd_tag_pipe (RD_LAT-deep {valid, port} shift register with async reset).
- The FSM, wait counter, mux and conflict counter stay in the top.

## Test plan
- **CPU-only access:** CPU write addr 0x010 data 0xDEADBEEF, then read 0x010.
  - Required: cpu_gnt both cycles, wren=1 only on the first.
  - Required: cpu_rvalid RD_LAT cycles after the read with rdata 0xDEADBEEF; aux_rvalid stays 0.
- **AUX-only reads:** AUX reads 0x000..0x003 back-to-back.
  - Required: four aux_gnt and four aux_rvalid in order, no cpu_stall.
- **Starvation bound:** both request continuously with MAX_WAIT=8.
  - Required: aux_gnt on cycles 9, 18, 27 (1-based); cpu_stall high exactly on those cycles.
  - Required: conflict_cnt counts every overlapped cycle.
- **Abandoned forced grant:** aux_req drops on the cycle FORCE_AUX is entered.
  - Required: no grant that cycle, state returns to PRI_CPU, and wait_cnt reads 0.
- **Reset mid-operation:** assert reset asynchronously between grant and rvalid of an AUX read.
  - Required: wren and gnt drop immediately and no aux_rvalid appears.
  - Required: conflict_cnt is 0 after release.
- **Saturation:** force 70000 conflict cycles.
  - Required: conflict_cnt holds at 16'hFFFF.
